// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - RV32I fetch stage: PC, imem read port and prefetch queue with redirect flush.
// Optional FETCH_MISALIGN_CHECK_EN adds a sticky misaligned-redirect halt.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h00001000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_address,
  input  logic [31:0] imem_data_out,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   r_fpc;
  logic          r_infl;
  logic [31:0]   r_infl_pc;
  logic [31:0]   r_q_instr [DEPTH];
  logic [31:0]   r_q_pc    [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic          w_pop;
  logic          w_push;
  logic          w_issue;
  logic          w_halted;
  logic [31:0]   w_redir_pc;
  logic [CW:0]   w_occ;

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic {ST_RUN, ST_HALT} state_t;
  state_t r_state;
  state_t w_state_nxt;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_RUN;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (redirect) begin
      w_state_nxt = (redirect_pc[1:0] != 2'b00) ? ST_HALT : ST_RUN;
    end
  end

  assign w_halted       = (r_state == ST_HALT);
  assign fetch_misalign = w_halted;
  assign w_redir_pc     = redirect_pc;
`else
  assign w_halted       = 1'b0;
  assign fetch_misalign = 1'b0;
  assign w_redir_pc     = redirect_pc & 32'hFFFF_FFFC;
`endif

  assign imem_address = r_fpc;
  assign instr_valid  = (r_count != '0);
  assign instr        = r_q_instr[r_rd_ptr];
  assign instr_pc     = r_q_pc[r_rd_ptr];
  assign w_pop        = instr_valid & instr_ready;
  assign w_push       = r_infl & ~redirect;

  // Credit counts the in-flight word so a returning word always has a slot.
  assign w_occ   = {1'b0, r_count} + (CW+1)'(r_infl) - (CW+1)'(w_pop);
  assign w_issue = ~redirect & ~w_halted & (w_occ < (CW+1)'(DEPTH));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_fpc     <= RESET_PC;
      r_infl    <= 1'b0;
      r_infl_pc <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_q_instr[i] <= '0;
        r_q_pc[i]    <= '0;
      end
    end else if (redirect) begin
      r_fpc    <= w_redir_pc;
      r_infl   <= 1'b0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_infl <= w_issue;
      if (w_issue) begin
        r_fpc     <= r_fpc + 32'd4;
        r_infl_pc <= r_fpc;
      end
      if (w_push) begin
        r_q_instr[r_wr_ptr] <= imem_data_out;
        r_q_pc[r_wr_ptr]    <= r_infl_pc;
        r_wr_ptr            <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed self-checking bench for fetch_unit; memory returns word = address.
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic [31:0] imem_address;
  logic [31:0] imem_data_out;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  int n_vec;
  int n_err;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .imem_address   (imem_address),
    .imem_data_out  (imem_data_out),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .fetch_misalign (fetch_misalign)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) imem_data_out <= imem_address;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic head(input string tag, input logic [31:0] pc);
    check({tag, ".valid"}, {31'd0, instr_valid}, 32'd1);
    check({tag, ".pc"}, instr_pc, pc);
    check({tag, ".instr"}, instr, pc);
  endtask

  // Leaves the bench in cycle 0 (first cycle with reset low).
  task automatic do_reset();
    reset       = 1'b1;
    redirect    = 1'b0;
    redirect_pc = 32'd0;
    instr_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    // Reset state and streaming with ready held high.
    do_reset();
    check("rst.addr", imem_address, 32'h1000);
    check("rst.valid", {31'd0, instr_valid}, 32'd0);
    check("rst.instr", instr, 32'd0);
    check("rst.pc", instr_pc, 32'd0);
    check("rst.mis", {31'd0, fetch_misalign}, 32'd0);
    instr_ready = 1'b1;
    tick();
    check("c1.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    head("c2", 32'h1000);
    tick();
    head("c3", 32'h1004);
    // Redirect while 0x100C is in flight (cycle 4).
    tick();
    head("c4", 32'h1008);
    redirect    = 1'b1;
    redirect_pc = 32'h1040;
    tick();
    redirect = 1'b0;
    check("rd.t1.valid", {31'd0, instr_valid}, 32'd0);
    check("rd.t1.addr", imem_address, 32'h1040);
    tick();
    check("rd.t2.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    head("rd.t3", 32'h1040);
    tick();
    head("rd.t4", 32'h1044);

    // Wrap of the fetch PC past 0xFFFFFFFC.
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    head("wrap0", 32'hFFFF_FFF8);
    tick();
    head("wrap1", 32'hFFFF_FFFC);
    tick();
    head("wrap2", 32'h0000_0000);

    // Back-to-back redirects: the second wins.
    redirect    = 1'b1;
    redirect_pc = 32'h3000;
    tick();
    redirect_pc = 32'h4000;
    tick();
    redirect = 1'b0;
    check("b2b.t1.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    check("b2b.t2.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    head("b2b.t3", 32'h4000);

    // Stall: queue fills with two entries, fetch address holds.
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("stall.addr", imem_address, 32'h1008);
    head("stall.hd", 32'h1000);
    instr_ready = 1'b1;
    tick();
    head("stall.r1", 32'h1004);
    tick();
    head("stall.r2", 32'h1008);
    tick();
    head("stall.r3", 32'h100C);

    // Toggling ready: delivered PCs stay strictly consecutive.
    do_reset();
    begin
      logic [31:0] exp_pc;
      int          got;
      exp_pc = 32'h1000;
      got    = 0;
      for (int i = 0; i < 20; i++) begin
        instr_ready = ~i[0];
        if (instr_valid && instr_ready) begin
          check("tog.pc", instr_pc, exp_pc);
          exp_pc = exp_pc + 32'd4;
          got++;
        end
        tick();
      end
      check("tog.count", {31'd0, got >= 8}, 32'd1);
    end

    // Misaligned redirect.
    do_reset();
    instr_ready = 1'b1;
    tick();
    tick();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h1042;
    tick();
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
    check("mis.flag", {31'd0, fetch_misalign}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    check("mis.valid", {31'd0, instr_valid}, 32'd0);
    check("mis.flag2", {31'd0, fetch_misalign}, 32'd1);
    redirect    = 1'b1;
    redirect_pc = 32'h1080;
    tick();
    redirect = 1'b0;
    check("mis.clr", {31'd0, fetch_misalign}, 32'd0);
    tick();
    tick();
    head("mis.t3", 32'h1080);
`else
    check("mis.flag", {31'd0, fetch_misalign}, 32'd0);
    check("mis.addr", imem_address, 32'h1040);
    tick();
    tick();
    head("mis.t3", 32'h1040);
`endif

    // Reset with full queue and redirect in the same cycle.
    do_reset();
    instr_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    head("full.hd", 32'h1000);
    reset       = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h2000;
    tick();
    check("rr.valid", {31'd0, instr_valid}, 32'd0);
    check("rr.addr", imem_address, 32'h1000);
    check("rr.pc", instr_pc, 32'd0);
    reset       = 1'b0;
    redirect    = 1'b0;
    instr_ready = 1'b1;
    tick();
    check("rr.c1.valid", {31'd0, instr_valid}, 32'd0);
    tick();
    head("rr.c2", 32'h1000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the multi-cycle RV32I core: owns the fetch PC, drives the instruction-memory read port, and buffers returned words with their PCs in a small prefetch queue. It feeds the instruction register/decoder through a valid/ready handshake. On a taken branch or jump it accepts a redirect, flushes queued and in-flight words, and resumes at the new PC.

## Interface
- RESET_PC, 32'h00001000: fetch PC loaded on reset.
- DEPTH, 2: prefetch queue entries; power of two, ≥2.
- clk  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- imem_address  out  32  instruction-memory read address; data returns one cycle later.
- imem_data_out  in  32  instruction-memory read data for the address presented in the previous cycle.
- instr_valid  out  1  queue head holds a valid instruction.
- instr  out  32  queue-head instruction word.
- instr_pc  out  32  PC of queue-head instruction.
- instr_ready  in  1  consumer accepts head this cycle when instr_valid=1.
- redirect  in  1  one-cycle pulse: flush and refetch from redirect_pc.
- redirect_pc  in  32  new fetch PC, sampled when redirect=1.
- fetch_misalign  out  1  sticky misaligned-redirect flag (only with FETCH_MISALIGN_CHECK_EN; else tied 0).

## Operation
- State: fetch PC fpc; in-flight flag infl plus its PC infl_pc; circular queue of DEPTH {instr, pc} entries with wr/rd pointers and count (width clog2(DEPTH)+1).
- imem_address = fpc, combinational.
- pop = instr_valid & instr_ready.
- issue = !redirect & !halted & (count + infl - pop < DEPTH); on issue fpc <= fpc+4 (mod 2^32, wraps 0xFFFFFFFC→0), infl <= 1, infl_pc <= fpc; else infl <= 0.
- push = infl & !redirect: write {imem_data_out, infl_pc} at wr pointer.
- count <= count + push - pop; push and pop in the same cycle leave count unchanged, including at count=DEPTH-1 and at count=DEPTH with a pop.
- The issue credit guarantees push never occurs with count=DEPTH after pop; queue cannot overflow.
- instr_valid = (count != 0); instr/instr_pc = entry at rd pointer; pop on empty is ignored.
- Redirect (priority over issue/push, below reset): a pop in the same cycle still completes; then count <= 0, pointers <= 0, infl <= 0 (the word returning next cycle is discarded), fpc <= redirect_pc.
- Pointers wrap modulo DEPTH.
- No FSM beyond halted (misalign only): RUN → HALT on misaligned redirect; HALT → RUN on an aligned redirect or reset.

## Timing
- Reset values: fpc=RESET_PC (so imem_address=RESET_PC), infl=0, count=0, instr_valid=0, instr=0, instr_pc=0 (queue storage cleared), fetch_misalign=0.
- Cycle 0 = first cycle with reset low: RESET_PC issued; cycle 1 word pushed; cycle 2 instr_valid=1, instr_pc=RESET_PC.
- With instr_ready held high: one instruction per cycle from cycle 2, PCs consecutive +4.
- Redirect in cycle t: instr_valid=0 in t+1 and t+2; redirect_pc issued in t+1; instr_valid=1 with instr_pc=redirect_pc in t+3.
- Back-to-back redirects: last one wins; each restarts the t+3 latency.
- reset asserted mid-stream: next cycle all state equals reset values regardless of redirect/queue contents.

## Configuration
- FETCH_MISALIGN_CHECK_EN defined: redirect with redirect_pc[1:0]≠0 sets fetch_misalign=1 and halted=1 (no issue, queue flushed, instr_valid stays 0) until an aligned redirect (clears both) or reset.
- Undefined: redirect_pc[1:0] forced to 2'b00; fetch_misalign tied 0; no halted state.

## Test plan
- Reset release, instr_ready=1, memory word = address: instr_valid rises cycle 2, instr_pc 0x1000,0x1004,0x1008… every cycle, instr == instr_pc.
- instr_ready=0 for 10 cycles after reset: queue holds 0x1000,0x1004; imem_address stalls at 0x1008; on ready=1 delivers 0x1000,0x1004,0x1008 with no loss or duplicate.
- Toggle instr_ready every cycle for 20 cycles: delivered PCs strictly consecutive, count never exceeds 2.
- Redirect to 0x1040 while 0x100C in flight: 0x100C never delivered; instr_valid low two cycles; next instr_pc=0x1040 at t+3.
- Redirect to 0x1042: with macro fetch_misalign=1, instr_valid stays 0 until redirect to 0x1080 (then 0x1080 at t+3, flag cleared); without macro instr_pc=0x1040.
- Reset with full queue and redirect same cycle: next cycle instr_valid=0, imem_address=0x1000, 0x1000 delivered cycle 2 after release.
